emergency_request_arbiter: RTL

- Sits directly upstream of `Traffic_Controller` and drives its `Emergency_left` / `Emergency_right` inputs.
- Takes raw, asynchronous siren-detector lines and synchronises and debounces them.
- Arbitrates so at most one direction is granted at a time, and shapes each grant into a bounded pulse: minimum hold, maximum hold, then cooldown.
- One clock cycle equals one second of controller time.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/sync_debounce.sv | 62 ++++++
 rtl/emergency_request_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
//   Shared types and default constants for the traffic controller slice.
//   Used by emergency_request_arbiter and sync_debounce.
//
//   em_state_t : emergency arbiter FSM state encoding
//   em_dir_t   : approach direction (LEFT / RIGHT)
//   DEF_*      : default values for the arbiter parameters
// ----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_L = 2'd1,
        GRANT_R = 2'd2,
        COOL    = 2'd3
    } em_state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } em_dir_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 3;
    localparam int DEF_MIN_HOLD        = 10;
    localparam int DEF_MAX_HOLD        = 30;
    localparam int DEF_COOLDOWN        = 5;

    // Which direction a grant state belongs to; anything else reports the
    // fallback direction supplied by the caller.
    function automatic em_dir_t grant_dir(input em_state_t st, input em_dir_t fallback);
        em_dir_t d;
        d = fallback;
        if (st == GRANT_L) d = LEFT;
        if (st == GRANT_R) d = RIGHT;
        return d;
    endfunction

endpackage : traffic_pkg

// File: rtl/sync_debounce.sv
// ----------------------------------------------------------------------------
// sync_debounce
//   Brings one asynchronous detector line into the clk domain and debounces
//   it. A SYNC_STAGES-deep flop chain feeds a counter that must see
//   DEBOUNCE_CYCLES consecutive samples differing from the debounced level
//   before the level flips.
//
//   Ports
//     clk     : system clock
//     rst     : asynchronous active-low reset
//     din_raw : raw asynchronous input
//     level   : debounced level
// ----------------------------------------------------------------------------
module sync_debounce
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   deb_q;
    logic [CW-1:0]          cnt_q;
    logic                   synced;
    logic                   flip;

    assign synced = sync_q[SYNC_STAGES-1];

    // The sample that completes the stable run flips the level on this edge.
    assign flip = (synced != deb_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    // level is the value deb_q takes at the coming edge. Handing that to the
    // arbiter lets the grant register rise on the same edge the debounced
    // level changes, instead of one cycle later.
    assign level = deb_q ^ flip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_raw};
            if (synced == deb_q) begin
                cnt_q <= '0;
            end else if (flip) begin
                deb_q <= ~deb_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule : sync_debounce

// File: rtl/emergency_request_arbiter.sv
// ----------------------------------------------------------------------------
// emergency_request_arbiter
//   Conditions the left/right siren detector lines, picks at most one
//   direction at a time and shapes the grant into a pulse of
//   [MIN_HOLD, MAX_HOLD] cycles followed by COOLDOWN cycles with both grants
//   low. Feeds Emergency_left / Emergency_right of Traffic_Controller.
//   One clk cycle is one second of controller time.
//
//   Ports
//     clk                       : system clock
//     rst                       : asynchronous active-low reset
//     siren_left_raw            : asynchronous left detector
//     siren_right_raw           : asynchronous right detector
//     Emergency_left            : registered left grant
//     Emergency_right           : registered right grant
//     em_active                 : either grant high
//     em_pending                : other side's debounced request during
//                                 grant or cooldown
//     served_left/served_right  : saturating 8-bit grant counts, only when
//                                 EMERG_SERVICE_COUNT_EN is defined
//
//   Configuration macro: EMERG_SERVICE_COUNT_EN
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no grant, waiting for a debounced request
//   GRANT_L | left granted, hold_cnt counting grant cycles
//   GRANT_R | right granted, hold_cnt counting grant cycles
//   COOL    | both grants low, cool_cnt counting down to re-arbitration
// ----------------------------------------------------------------------------
module emergency_request_arbiter
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MIN_HOLD        = DEF_MIN_HOLD,
    parameter int MAX_HOLD        = DEF_MAX_HOLD,
    parameter int COOLDOWN        = DEF_COOLDOWN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       siren_left_raw,
    input  logic       siren_right_raw,
    output logic       Emergency_left,
    output logic       Emergency_right,
    output logic       em_active,
    output logic       em_pending
`ifdef EMERG_SERVICE_COUNT_EN
    ,
    output logic [7:0] served_left,
    output logic [7:0] served_right
`endif
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int CW = $clog2(COOLDOWN + 1);

    em_state_t     state_q;
    em_state_t     state_d;
    em_state_t     idle_pick;
    em_dir_t       last_q;
    em_dir_t       served_dir;
    logic [HW-1:0] hold_q;
    logic [CW-1:0] cool_q;
    logic          req_l;
    logic          req_r;
    logic          hold_done_l;
    logic          hold_done_r;
    logic          pending_d;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_left (
        .clk     (clk),
        .rst     (rst),
        .din_raw (siren_left_raw),
        .level   (req_l)
    );

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_right (
        .clk     (clk),
        .rst     (rst),
        .din_raw (siren_right_raw),
        .level   (req_r)
    );

    // Arbitration used both from IDLE and at the last cooldown cycle.
    // A tie goes to the side that was not served last.
    always_comb begin
        idle_pick = IDLE;
        if (req_l && req_r) begin
            idle_pick = (last_q == RIGHT) ? GRANT_L : GRANT_R;
        end else if (req_l) begin
            idle_pick = GRANT_L;
        end else if (req_r) begin
            idle_pick = GRANT_R;
        end
    end

    assign hold_done_l = (hold_q == HW'(MAX_HOLD)) ||
                         ((hold_q >= HW'(MIN_HOLD)) && !req_l);
    assign hold_done_r = (hold_q == HW'(MAX_HOLD)) ||
                         ((hold_q >= HW'(MIN_HOLD)) && !req_r);

    // The final cooldown cycle arbitrates directly, so a request that is
    // still up sees exactly COOLDOWN low cycles between two grants.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = idle_pick;
            GRANT_L: if (hold_done_l) state_d = COOL;
            GRANT_R: if (hold_done_r) state_d = COOL;
            COOL:    if (cool_q <= CW'(1)) state_d = idle_pick;
            default: state_d = IDLE;
        endcase
    end

    // Side that owns the grant or cooldown after this edge; pending shows
    // the opposite side's request.
    assign served_dir = grant_dir(state_q, last_q);

    always_comb begin
        pending_d = 1'b0;
        case (state_d)
            GRANT_L: pending_d = req_r;
            GRANT_R: pending_d = req_l;
            COOL:    pending_d = (served_dir == LEFT) ? req_r : req_l;
            default: pending_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            hold_q          <= '0;
            cool_q          <= '0;
            last_q          <= RIGHT;
            Emergency_left  <= 1'b0;
            Emergency_right <= 1'b0;
            em_active       <= 1'b0;
            em_pending      <= 1'b0;
`ifdef EMERG_SERVICE_COUNT_EN
            served_left     <= 8'd0;
            served_right    <= 8'd0;
`endif
        end else begin
            state_q <= state_d;

            if (state_d == GRANT_L || state_d == GRANT_R) begin
                hold_q <= (state_d == state_q) ? hold_q + 1'b1 : HW'(1);
            end else begin
                hold_q <= '0;
            end

            if (state_d == COOL) begin
                cool_q <= (state_q == COOL) ? cool_q - 1'b1 : CW'(COOLDOWN);
            end else begin
                cool_q <= '0;
            end

            if (state_d == COOL && state_q != COOL) begin
                last_q <= served_dir;
            end

            Emergency_left  <= (state_d == GRANT_L);
            Emergency_right <= (state_d == GRANT_R);
            em_active       <= (state_d == GRANT_L) || (state_d == GRANT_R);
            em_pending      <= pending_d;

`ifdef EMERG_SERVICE_COUNT_EN
            if (state_d == GRANT_L && state_q != GRANT_L && served_left != 8'hFF) begin
                served_left <= served_left + 8'd1;
            end
            if (state_d == GRANT_R && state_q != GRANT_R && served_right != 8'hFF) begin
                served_right <= served_right + 8'd1;
            end
`endif
        end
    end

endmodule : emergency_request_arbiter
